// File: rtl/x74_lut_array.sv
// N-channel 2-input programmable gate array; truth tables loaded over a chainable serial port.
// Latency: y is 1 cycle after a/b when REG_OUT=1, combinational when REG_OUT=0; a load reaches f one cycle after its edge.
// Backpressure: none; cfg_shift and cfg_load are sampled on every rising edge, with no handshake.
module x74_lut_array #(
    parameter int         N         = 4,
    parameter bit         REG_OUT   = 1'b1,
    parameter logic [3:0] CFG_RESET = 4'b1000
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    input  logic         cfg_sdi,
    input  logic         cfg_shift,
    input  logic         cfg_load,
    output logic         cfg_sdo,
    output logic         cfg_full
);

    localparam int             W      = 4 * N;
    localparam int             CW     = $clog2(W + 1);
    localparam logic [CW-1:0]  C_FULL = CW'(W);
    localparam logic [CW-1:0]  C_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [W-1:0]  r_sreg;
    logic [W-1:0]  r_lut;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_f;

    // Serial shift register; MSB is the chain output.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sreg <= '0;
        end else if (cfg_shift) begin
            r_sreg <= {r_sreg[W-2:0], cfg_sdi};
        end
    end

    // Active tables capture the pre-shift register contents on a load.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_lut <= {N{CFG_RESET}};
        end else if (cfg_load) begin
            r_lut <= r_sreg;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (cfg_load) begin
            r_cnt <= cfg_shift ? C_ONE : '0;
        end else if (cfg_shift && (r_cnt != C_FULL)) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign cfg_sdo  = r_sreg[W-1];
    assign cfg_full = (r_cnt == C_FULL);

    // {a,b} selects one bit of the channel's 4-bit truth table, a being the MSB.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic [3:0] w_tt;
        assign w_tt    = r_lut[4*gi +: 4];
        assign w_f[gi] = w_tt[{a[gi], b[gi]}];
    end

    if (REG_OUT) begin : g_reg
        logic [N-1:0] r_y;
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_y <= '0;
            end else begin
                r_y <= w_f;
            end
        end
        assign y = r_y;
    end else begin : g_comb
        assign y = w_f;
    end

endmodule

// File: tb/tb_x74_lut_array.sv
// Bench for x74_lut_array: a registered 4-channel instance and a combinational 1-channel instance.
module tb_x74_lut_array;

    logic       clk = 1'b0;
    logic       nreset, nreset1;
    logic [3:0] a, b, y;
    logic       sdi, shift, load, sdo, full;
    logic [0:0] a1, b1, y1;
    logic       sdi1, shift1, load1, sdo1, full1;

    int total = 0;
    int bad   = 0;

    logic [3:0] q4[$];
    logic [0:0] q1[$];
    logic [15:0] m_lut;

    always #5 clk = ~clk;

    x74_lut_array #(.N(4), .REG_OUT(1'b1), .CFG_RESET(4'b1000)) dut (
        .clk(clk), .nreset(nreset), .a(a), .b(b), .y(y),
        .cfg_sdi(sdi), .cfg_shift(shift), .cfg_load(load),
        .cfg_sdo(sdo), .cfg_full(full)
    );

    x74_lut_array #(.N(1), .REG_OUT(1'b0), .CFG_RESET(4'b1000)) dut1 (
        .clk(clk), .nreset(nreset1), .a(a1), .b(b1), .y(y1),
        .cfg_sdi(sdi1), .cfg_shift(shift1), .cfg_load(load1),
        .cfg_sdo(sdo1), .cfg_full(full1)
    );

    // Reference evaluation straight from the truth-table definition.
    function automatic logic [3:0] gate_model(input logic [15:0] lut, input logic [3:0] ia, input logic [3:0] ib);
        logic [3:0] r;
        logic [3:0] tt;
        for (int i = 0; i < 4; i++) begin
            tt   = lut[4*i +: 4];
            r[i] = tt[{ia[i], ib[i]}];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_y;
        nreset = 1'b0; nreset1 = 1'b0;
        a = 4'b1010; b = 4'b1100; sdi = 1'b0; shift = 1'b0; load = 1'b0;
        a1 = 1'b1; b1 = 1'b1; sdi1 = 1'b0; shift1 = 1'b0; load1 = 1'b0;
        m_lut = 16'h8888;
        tick(); tick();
        total++; if (y !== 4'b0000) begin bad++; $display("FAIL reset_y got=%b want=0000", y); end
        total++; if (sdo !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL reset_cfg got sdo=%b full=%b want 0 0", sdo, full); end
        total++; if (dut.r_lut !== 16'h8888) begin bad++; $display("FAIL reset_lut got=%h want=8888", dut.r_lut); end
        nreset = 1'b1;
        a = 4'b1010; b = 4'b1100;
        q4.push_back(gate_model(m_lut, a, b));
        tick();
        exp_y = q4.pop_front();
        total++; if (y !== exp_y || y !== 4'b1000) begin bad++; $display("FAIL default_and got=%b want=%b", y, exp_y); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL default_full got=%b want=0", full); end
    endtask

    task automatic test_reprogram();
        logic [15:0] pat;
        logic [3:0]  exp_y;
        pat = 16'h6E78;
        for (int k = 15; k >= 0; k--) begin
            sdi = pat[k]; shift = 1'b1;
            tick();
            if (k == 1) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL full_early got=%b want=0 after 15 shifts", full); end
            end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_16 got=%b want=1", full); end
        total++; if (dut.r_sreg !== pat) begin bad++; $display("FAIL sreg_pat got=%h want=%h", dut.r_sreg, pat); end
        shift = 1'b0; load = 1'b1; a = 4'b1111; b = 4'b0000;
        q4.push_back(gate_model(m_lut, a, b));
        m_lut = pat;
        q4.push_back(gate_model(m_lut, a, b));
        tick();
        load = 1'b0;
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full_after_load got=%b want=0", full); end
        total++; if (dut.r_lut !== pat) begin bad++; $display("FAIL lut_loaded got=%h want=%h", dut.r_lut, pat); end
        exp_y = q4.pop_front();
        total++; if (y !== exp_y) begin bad++; $display("FAIL y_load_plus1 got=%b want=%b", y, exp_y); end
        tick();
        exp_y = q4.pop_front();
        // XOR, OR, NAND, AND with a=1,b=0 each pick table bit 2.
        total++; if (y !== exp_y || y !== 4'b1110) begin bad++; $display("FAIL y_mixed got=%b want=%b", y, exp_y); end
    endtask

    task automatic test_saturation();
        logic [19:0] pat;
        pat = 20'hB1234;
        for (int k = 1; k <= 20; k++) begin
            sdi = pat[20-k]; shift = 1'b1;
            tick();
            if (k >= 16) begin
                total++; if (dut.r_cnt !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL sat_cnt edge=%0d got cnt=%0d full=%b want 16 1", k, dut.r_cnt, full); end
                total++; if (sdo !== pat[19-(k-16)]) begin bad++; $display("FAIL sat_sdo edge=%0d got=%b want=%b", k, sdo, pat[19-(k-16)]); end
            end
        end
        shift = 1'b0;
        total++; if (dut.r_sreg !== 16'h1234) begin bad++; $display("FAIL sat_sreg got=%h want=1234", dut.r_sreg); end
    endtask

    task automatic test_shift_load();
        logic [15:0] pat;
        pat = 16'hF00F;
        for (int k = 15; k >= 0; k--) begin
            sdi = pat[k]; shift = 1'b1;
            tick();
        end
        sdi = 1'b1; shift = 1'b1; load = 1'b1;
        tick();
        shift = 1'b0; load = 1'b0; sdi = 1'b0;
        m_lut = pat;
        total++; if (dut.r_lut !== 16'hF00F) begin bad++; $display("FAIL sl_lut got=%h want=f00f", dut.r_lut); end
        total++; if (dut.r_sreg !== 16'hE01F) begin bad++; $display("FAIL sl_sreg got=%h want=e01f", dut.r_sreg); end
        total++; if (dut.r_cnt !== 5'd1 || full !== 1'b0) begin bad++; $display("FAIL sl_cnt got cnt=%0d full=%b want 1 0", dut.r_cnt, full); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pat;
        logic [3:0]  exp_y;
        pat = 16'h6666;
        for (int k = 15; k >= 0; k--) begin
            sdi = pat[k]; shift = 1'b1;
            tick();
        end
        shift = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        m_lut = pat;
        a = 4'b1111; b = 4'b0000;
        q4.push_back(gate_model(m_lut, a, b));
        tick();
        exp_y = q4.pop_front();
        total++; if (y !== exp_y) begin bad++; $display("FAIL xor_before_rst got=%b want=%b", y, exp_y); end
        for (int k = 0; k < 9; k++) begin
            sdi = 1'b1; shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        m_lut = 16'h8888;
        total++; if (dut.r_lut !== 16'h8888 || dut.r_sreg !== 16'h0000) begin bad++; $display("FAIL midrst_state got lut=%h sreg=%h want 8888 0000", dut.r_lut, dut.r_sreg); end
        total++; if (dut.r_cnt !== 5'd0 || y !== 4'b0000 || sdo !== 1'b0) begin bad++; $display("FAIL midrst_out got cnt=%0d y=%b sdo=%b want 0 0000 0", dut.r_cnt, y, sdo); end
        tick();
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_comb();
        logic [15:0] m1;
        logic [3:0]  pat;
        logic [0:0]  e;
        m1 = 16'h8888;
        a1 = 1'b1; b1 = 1'b1;
        #1;
        q1.push_back(gate_model(m1, {3'b0, a1}, {3'b0, b1}) & 4'b0001);
        e = q1.pop_front();
        total++; if (y1 !== e || y1 !== 1'b1) begin bad++; $display("FAIL comb_rst_and got=%b want=%b", y1, e); end
        tick();
        nreset1 = 1'b1;
        pat = 4'b0001;
        for (int k = 3; k >= 0; k--) begin
            sdi1 = pat[k]; shift1 = 1'b1;
            tick();
        end
        shift1 = 1'b0;
        total++; if (full1 !== 1'b1) begin bad++; $display("FAIL comb_full got=%b want=1", full1); end
        a1 = 1'b0; b1 = 1'b0;
        #1;
        q1.push_back(gate_model(m1, {3'b0, a1}, {3'b0, b1}) & 4'b0001);
        e = q1.pop_front();
        total++; if (y1 !== e) begin bad++; $display("FAIL comb_and00 got=%b want=%b", y1, e); end
        load1 = 1'b1;
        tick();
        load1 = 1'b0;
        m1 = {12'h000, pat};
        q1.push_back(gate_model(m1, 4'b0000, 4'b0000) & 4'b0001);
        e = q1.pop_front();
        total++; if (y1 !== e || y1 !== 1'b1) begin bad++; $display("FAIL comb_nor00 got=%b want=%b", y1, e); end
        a1 = 1'b1; b1 = 1'b0;
        #1;
        q1.push_back(gate_model(m1, {3'b0, a1}, {3'b0, b1}) & 4'b0001);
        e = q1.pop_front();
        total++; if (y1 !== e || y1 !== 1'b0) begin bad++; $display("FAIL comb_nor10 got=%b want=%b", y1, e); end
    endtask

    initial begin
        test_reset();
        test_reprogram();
        test_saturation();
        test_shift_load();
        test_reset_mid();
        test_comb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
